// File: rtl/cdu_pkg.sv
// cdu_pkg: shared types and widths for the CDU read-counter slice.
//   phase_e  : the four digital-mode phases, in cycle order
//   dir_e    : increment direction chosen for the current phase cycle
//   next_phase(): the phase that must follow a given phase
package cdu_pkg;

  localparam int ANGLE_W = 16;
  localparam int PEND_W  = 3;

  typedef enum logic [1:0] {PH1, PH2, PH3, PH4} phase_e;
  typedef enum logic [1:0] {NONE, UP, DN} dir_e;

  // PH4 wraps to PH1 through the 2-bit encoding.
  function automatic phase_e next_phase(input phase_e p);
    return phase_e'(p + 2'd1);
  endfunction

endpackage

// File: rtl/cdu_sync2.sv
// cdu_sync2: two-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector on the synchronised level.
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset, clears all flops
//   async_in : asynchronous level input
//   rise     : one-clk pulse when the synchronised level goes 0 -> 1
module cdu_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // [0] first sync stage, [1] second sync stage, [2] previous synced level
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/cdu_read_counter.sv
// cdu_read_counter: serialises asynchronous resolver up/down increments onto the
// FAZ1..FAZ4 phase cycle, keeps the 16-bit read-counter angle and emits one
// rate-limited AGC pulse per applied increment. Polices the phase order and
// flags pending-request overflow.
//   clk, rst_n           : clock, asynchronous active-low reset
//   FAZ1HI..FAZ4DR       : phase levels from digital_mode
//   ISSUP, ISSDN         : asynchronous increment requests (level)
//   CLR_ERR              : synchronous clear of the sticky error flags
//   ANGLE                : read-counter angle, wraps mod 2^16
//   CDUP, CDUM           : AGC plus/minus pulse, high across FAZ4
//   PEND_OVF, PHASE_ERR  : sticky error flags
//
// Phase tracker (exp_ph = phase whose rising edge is expected next)
//   state | meaning
//   PH1   | idle between cycles; FAZ1 edge ends any pulse, clears selection
//   PH2   | FAZ2 edge selects UP/DN/NONE or cancels an opposing pair
//   PH3   | FAZ3 edge applies the selected increment to ANGLE
//   PH4   | FAZ4 edge raises CDUP/CDUM for the selected direction
module cdu_read_counter
  import cdu_pkg::*;
#(
  parameter int PEND_MAX = 7,
  parameter int RATE_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               FAZ1HI,
  input  logic               FAZ2DR,
  input  logic               FAZ3DR,
  input  logic               FAZ4DR,
  input  logic               ISSUP,
  input  logic               ISSDN,
  input  logic               CLR_ERR,
  output logic [ANGLE_W-1:0] ANGLE,
  output logic               CDUP,
  output logic               CDUM,
  output logic               PEND_OVF,
  output logic               PHASE_ERR
);

  localparam logic [PEND_W-1:0] PEND_LIM  = PEND_W'(PEND_MAX);
  localparam logic [3:0]        RATE_LOAD = 4'(RATE_DIV - 1);

  logic [3:0]        faz_lvl;
  logic [3:0]        faz_q;
  logic [3:0]        faz_rise;
  logic              faz4_fall;
  logic              any_edge;
  logic              multi_edge;
  logic              good_edge;
  logic              phase_bad;
  phase_e            exp_ph;
  phase_e            seen_ph;
  dir_e              sel_dir;
  dir_e              dir_pick;
  logic [3:0]        rate_cnt;
  logic [PEND_W-1:0] pend_up;
  logic [PEND_W-1:0] pend_dn;
  logic              up_rise;
  logic              dn_rise;
  logic              up_dec;
  logic              dn_dec;
  logic              cancel;
  logic              ovf_set;

  cdu_sync2 u_sync_up (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ISSUP),
    .rise     (up_rise)
  );

  cdu_sync2 u_sync_dn (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ISSDN),
    .rise     (dn_rise)
  );

  // Phase edge detection; phase levels are already in the clk domain.
  assign faz_lvl   = {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1HI};
  assign faz_rise  = faz_lvl & ~faz_q;
  assign faz4_fall = faz_q[3] & ~FAZ4DR;
  assign any_edge  = |faz_rise;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi_edge = (faz_rise & (faz_rise - 4'd1)) != 4'd0;
  assign good_edge  = any_edge && !multi_edge && faz_rise[exp_ph];
  assign phase_bad  = any_edge && !good_edge;

  // Highest-numbered phase seen this clk; used to resync after an error.
  always_comb begin
    seen_ph = PH1;
    for (int i = 0; i < 4; i++) begin
      if (faz_rise[i]) seen_ph = phase_e'(i[1:0]);
    end
  end

  always_comb begin
    cancel   = (pend_up != '0) && (pend_dn != '0);
    dir_pick = NONE;
    if (!cancel && rate_cnt == 4'd0) begin
      if (pend_up != '0)      dir_pick = UP;
      else if (pend_dn != '0) dir_pick = DN;
    end
  end

  assign up_dec = (good_edge && exp_ph == PH2 && cancel) ||
                  (good_edge && exp_ph == PH3 && sel_dir == UP);
  assign dn_dec = (good_edge && exp_ph == PH2 && cancel) ||
                  (good_edge && exp_ph == PH3 && sel_dir == DN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      faz_q <= 4'b0000;
    end else begin
      faz_q <= faz_lvl;
    end
  end

  // Phase tracker, select/apply pipeline and pulse shaper.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ph   <= PH1;
      sel_dir  <= NONE;
      rate_cnt <= 4'd0;
      ANGLE    <= '0;
      CDUP     <= 1'b0;
      CDUM     <= 1'b0;
    end else begin
      if (phase_bad) begin
        // Abort the cycle: nothing selected survives to FAZ3/FAZ4.
        exp_ph  <= next_phase(seen_ph);
        sel_dir <= NONE;
        CDUP    <= 1'b0;
        CDUM    <= 1'b0;
      end else if (good_edge) begin
        exp_ph <= next_phase(exp_ph);
        case (exp_ph)
          PH1: begin
            sel_dir <= NONE;
            CDUP    <= 1'b0;
            CDUM    <= 1'b0;
          end
          PH2: begin
            sel_dir <= dir_pick;
            if (dir_pick != NONE)      rate_cnt <= RATE_LOAD;
            else if (rate_cnt != 4'd0) rate_cnt <= rate_cnt - 4'd1;
          end
          PH3: begin
            if (sel_dir == UP)      ANGLE <= ANGLE + 16'd1;
            else if (sel_dir == DN) ANGLE <= ANGLE - 16'd1;
          end
          PH4: begin
            CDUP <= (sel_dir == UP);
            CDUM <= (sel_dir == DN);
          end
        endcase
      end
      if (faz4_fall) begin
        CDUP <= 1'b0;
        CDUM <= 1'b0;
      end
    end
  end

  // Pending counters: a request edge and a consumption in the same clk cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_up <= '0;
    end else if (up_rise && !up_dec) begin
      if (pend_up != PEND_LIM) pend_up <= pend_up + 1'b1;
    end else if (!up_rise && up_dec) begin
      pend_up <= pend_up - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dn <= '0;
    end else if (dn_rise && !dn_dec) begin
      if (pend_dn != PEND_LIM) pend_dn <= pend_dn + 1'b1;
    end else if (!dn_rise && dn_dec) begin
      pend_dn <= pend_dn - 1'b1;
    end
  end

  assign ovf_set = (up_rise && pend_up == PEND_LIM) ||
                   (dn_rise && pend_dn == PEND_LIM);

  // Sticky flags: a set in the same clk as CLR_ERR wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PEND_OVF  <= 1'b0;
      PHASE_ERR <= 1'b0;
    end else begin
      if (ovf_set)      PEND_OVF <= 1'b1;
      else if (CLR_ERR) PEND_OVF <= 1'b0;
      if (phase_bad)    PHASE_ERR <= 1'b1;
      else if (CLR_ERR) PHASE_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdu_read_counter.sv
// tb_cdu_read_counter: scenario tasks driving phase cycles and resolver
// requests into cdu_read_counter (RATE_DIV=3), compared against a per-cycle
// arithmetic model of pending counts, rate spacing and angle.
module tb_cdu_read_counter;

  localparam int RDIV = 3;
  localparam int PMAX = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        FAZ1HI, FAZ2DR, FAZ3DR, FAZ4DR;
  logic        ISSUP, ISSDN, CLR_ERR;
  logic [15:0] ANGLE;
  logic        CDUP, CDUM, PEND_OVF, PHASE_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_up, m_dn, m_rate;
  logic [15:0] m_angle;
  bit          m_ovf, m_perr;

  always #5 clk = ~clk;

  cdu_read_counter #(.PEND_MAX(PMAX), .RATE_DIV(RDIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .FAZ1HI    (FAZ1HI),
    .FAZ2DR    (FAZ2DR),
    .FAZ3DR    (FAZ3DR),
    .FAZ4DR    (FAZ4DR),
    .ISSUP     (ISSUP),
    .ISSDN     (ISSDN),
    .CLR_ERR   (CLR_ERR),
    .ANGLE     (ANGLE),
    .CDUP      (CDUP),
    .CDUM      (CDUM),
    .PEND_OVF  (PEND_OVF),
    .PHASE_ERR (PHASE_ERR)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(input int ph);
    FAZ1HI = (ph == 1);
    FAZ2DR = (ph == 2);
    FAZ3DR = (ph == 3);
    FAZ4DR = (ph == 4);
  endtask

  task automatic model_reset();
    m_up = 0; m_dn = 0; m_rate = 0; m_angle = 16'h0000; m_ovf = 0; m_perr = 0;
  endtask

  // Every request edge adds one to its pending count, saturating with overflow.
  task automatic model_req(input int nu, input int nd);
    for (int k = 0; k < nu; k++) begin
      if (m_up == PMAX) m_ovf = 1; else m_up++;
    end
    for (int k = 0; k < nd; k++) begin
      if (m_dn == PMAX) m_ovf = 1; else m_dn++;
    end
  endtask

  // One clean phase cycle; dir: 0 none, 1 up, 2 down.
  task automatic model_cycle(output int dir);
    dir = 0;
    if (m_up > 0 && m_dn > 0) begin
      m_up--; m_dn--;
    end else if (m_rate == 0 && m_up > 0) begin
      dir = 1;
    end else if (m_rate == 0 && m_dn > 0) begin
      dir = 2;
    end
    if (dir != 0) m_rate = RDIV - 1;
    else if (m_rate > 0) m_rate--;
    if (dir == 1) begin m_up--; m_angle = m_angle + 16'd1; end
    if (dir == 2) begin m_dn--; m_angle = m_angle - 16'd1; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_phase(0);
    ISSUP = 1'b0; ISSDN = 1'b0; CLR_ERR = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    model_reset();
  endtask

  // nu up and nd down request pulses, the k-th of each launched together.
  task automatic send_req(input int nu, input int nd);
    int n;
    n = (nu > nd) ? nu : nd;
    for (int k = 0; k < n; k++) begin
      ISSUP = (k < nu);
      ISSDN = (k < nd);
      tick(); tick();
      ISSUP = 1'b0;
      ISSDN = 1'b0;
      tick(); tick();
    end
    model_req(nu, nd);
  endtask

  task automatic pulse_clr();
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    tick();
  endtask

  // Drives one phase cycle (3 clks per phase, then an idle gap) and reports
  // the angle before/after, whether a full-FAZ4 pulse appeared, and any pulse
  // activity outside FAZ4 or with both outputs high.
  task automatic run_cycle(input bit skip2, output logic [15:0] a_pre,
                           output logic [15:0] a_post, output bit up_p,
                           output bit dn_p, output bit stray);
    stray = 0; up_p = 0; dn_p = 0;
    a_pre = ANGLE;
    for (int ph = 1; ph <= 4; ph++) begin
      if (ph == 2 && skip2) continue;
      set_phase(ph);
      for (int s = 1; s <= 3; s++) begin
        @(negedge clk);
        if (CDUP && CDUM) stray = 1;
        if (ph == 4 && s >= 2) begin
          if (s == 2) begin
            up_p = CDUP;
            dn_p = CDUM;
          end else if (CDUP != up_p || CDUM != dn_p) begin
            stray = 1;
          end
        end else if (CDUP || CDUM) begin
          stray = 1;
        end
      end
      tick();
    end
    a_post = ANGLE;
    set_phase(0);
    @(posedge clk);
    @(negedge clk);
    if (CDUP || CDUM) stray = 1;
    tick();
  endtask

  task automatic test_reset();
    logic [15:0] a0, a1;
    bit u, d, s;
    rst_n = 1'b0;
    set_phase(0);
    ISSUP = 1'b0; ISSDN = 1'b0; CLR_ERR = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({ANGLE, CDUP, CDUM, PEND_OVF, PHASE_ERR} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_values: got %h required %h", {ANGLE, CDUP, CDUM, PEND_OVF, PHASE_ERR}, 20'h0);
    end
    do_reset();
    for (int c = 0; c < 4; c++) begin
      run_cycle(0, a0, a1, u, d, s);
      n_checks++;
      if ({a1, u, d, s, PHASE_ERR, PEND_OVF} !== 21'h0) begin
        n_fail++;
        $display("FAIL idle_cycle%0d: got %h required %h", c, {a1, u, d, s, PHASE_ERR, PEND_OVF}, 21'h0);
      end
    end
  endtask

  task automatic test_single_up();
    logic [15:0] a0, a1;
    bit u, d, s;
    do_reset();
    send_req(1, 0);
    run_cycle(0, a0, a1, u, d, s);
    n_checks++;
    if ({a0, a1, u, d, s} !== {16'h0000, 16'h0001, 3'b100}) begin
      n_fail++;
      $display("FAIL single_up: got %h required %h", {a0, a1, u, d, s}, {16'h0000, 16'h0001, 3'b100});
    end
  endtask

  task automatic test_down_wrap();
    logic [15:0] a0, a1;
    bit u, d, s;
    logic [6:0] up_mask;
    bit any_dn, any_stray;
    do_reset();
    send_req(0, 1);
    run_cycle(0, a0, a1, u, d, s);
    n_checks++;
    if ({a1, u, d, s} !== {16'hFFFF, 3'b010}) begin
      n_fail++;
      $display("FAIL down_wrap: got %h required %h", {a1, u, d, s}, {16'hFFFF, 3'b010});
    end
    send_req(2, 0);
    up_mask = '0; any_dn = 0; any_stray = 0;
    for (int c = 0; c < 7; c++) begin
      run_cycle(0, a0, a1, u, d, s);
      up_mask[c] = u;
      any_dn |= d;
      any_stray |= s;
    end
    // Rate spacing of 3 after the DN pulse puts the UPs in cycles 2 and 5.
    n_checks++;
    if ({ANGLE, up_mask, any_dn, any_stray} !== {16'h0001, 7'b0100100, 2'b00}) begin
      n_fail++;
      $display("FAIL up_after_wrap: got %h required %h", {ANGLE, up_mask, any_dn, any_stray}, {16'h0001, 7'b0100100, 2'b00});
    end
  endtask

  task automatic test_cancel();
    logic [15:0] a0, a1;
    bit u, d, s, any_p;
    do_reset();
    send_req(1, 1);
    run_cycle(0, a0, a1, u, d, s);
    n_checks++;
    if ({a1, u, d, s} !== 19'h0) begin
      n_fail++;
      $display("FAIL cancel: got %h required %h", {a1, u, d, s}, 19'h0);
    end
    any_p = 0;
    for (int c = 0; c < 3; c++) begin
      run_cycle(0, a0, a1, u, d, s);
      any_p |= u | d | s;
    end
    n_checks++;
    if ({ANGLE, any_p} !== 17'h0) begin
      n_fail++;
      $display("FAIL cancel_drained: got %h required %h", {ANGLE, any_p}, 17'h0);
    end
  endtask

  task automatic test_rate_ovf();
    logic [15:0] a0, a1;
    bit u, d, s;
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      send_req(1, 0);
      n_checks++;
      if (PEND_OVF !== (k >= 8)) begin
        n_fail++;
        $display("FAIL ovf_after_req%0d: got %b required %b", k, PEND_OVF, (k >= 8));
      end
    end
    for (int c = 0; c < 21; c++) begin
      run_cycle(0, a0, a1, u, d, s);
      n_checks++;
      if ({u, d, s} !== {(c % 3 == 0), 2'b00}) begin
        n_fail++;
        $display("FAIL rate_cycle%0d: got %b required %b", c, {u, d, s}, {(c % 3 == 0), 2'b00});
      end
    end
    n_checks++;
    if ({ANGLE, PEND_OVF} !== {16'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL rate_total: got %h required %h", {ANGLE, PEND_OVF}, {16'd7, 1'b1});
    end
  endtask

  task automatic test_phase_err();
    logic [15:0] a0, a1;
    bit u, d, s;
    do_reset();
    send_req(1, 0);
    run_cycle(1, a0, a1, u, d, s);
    n_checks++;
    if ({PHASE_ERR, a1, u, d, s} !== {1'b1, 16'h0000, 3'b000}) begin
      n_fail++;
      $display("FAIL skip_faz2: got %h required %h", {PHASE_ERR, a1, u, d, s}, {1'b1, 16'h0000, 3'b000});
    end
    run_cycle(0, a0, a1, u, d, s);
    n_checks++;
    if ({PHASE_ERR, a1, u, d, s} !== {1'b1, 16'h0001, 3'b100}) begin
      n_fail++;
      $display("FAIL resync_apply: got %h required %h", {PHASE_ERR, a1, u, d, s}, {1'b1, 16'h0001, 3'b100});
    end
    pulse_clr();
    n_checks++;
    if (PHASE_ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_err: got %b required 0", PHASE_ERR);
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [15:0] a0, a1;
    bit u, d, s;
    do_reset();
    send_req(1, 0);
    for (int ph = 1; ph <= 4; ph++) begin
      set_phase(ph);
      repeat (3) tick();
    end
    @(negedge clk);
    n_checks++;
    if ({CDUP, ANGLE} !== {1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %h required %h", {CDUP, ANGLE}, {1'b1, 16'h0001});
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ANGLE, CDUP, CDUM, PEND_OVF, PHASE_ERR} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got %h required %h", {ANGLE, CDUP, CDUM, PEND_OVF, PHASE_ERR}, 20'h0);
    end
    set_phase(0);
    tick();
    do_reset();
    // Reset between SELECT and APPLY must drop the pending increment too.
    send_req(1, 0);
    set_phase(1); repeat (3) tick();
    set_phase(2); repeat (3) tick();
    do_reset();
    run_cycle(0, a0, a1, u, d, s);
    n_checks++;
    if ({a1, u, d, s, PHASE_ERR} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_drops_select: got %h required %h", {a1, u, d, s, PHASE_ERR}, 20'h0);
    end
  endtask

  task automatic test_random();
    logic [15:0] a0, a1, exp_pre;
    bit u, d, s, skip;
    int nu, nd, dir;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      nu = $urandom_range(0, 2);
      nd = $urandom_range(0, 2);
      send_req(nu, nd);
      skip = ($urandom_range(0, 9) == 0);
      exp_pre = m_angle;
      if (skip) begin
        dir = 0;
        m_perr = 1;
      end else begin
        model_cycle(dir);
      end
      run_cycle(skip, a0, a1, u, d, s);
      n_checks++;
      if ({a0, a1, u, d, s, PEND_OVF, PHASE_ERR} !==
          {exp_pre, m_angle, (dir == 1), (dir == 2), 1'b0, m_ovf, m_perr}) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h required %h", c,
                 {a0, a1, u, d, s, PEND_OVF, PHASE_ERR},
                 {exp_pre, m_angle, (dir == 1), (dir == 2), 1'b0, m_ovf, m_perr});
      end
      if ($urandom_range(0, 5) == 0) begin
        pulse_clr();
        m_ovf = 0;
        m_perr = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_phase(0);
    ISSUP = 1'b0; ISSDN = 1'b0; CLR_ERR = 1'b0;
    model_reset();
    test_reset();
    test_single_up();
    test_down_wrap();
    test_cancel();
    test_rate_ovf();
    test_phase_err();
    test_reset_mid_pulse();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
